// File: rtl/wavetable_voice_sched.sv
// Shares one registered sample ROM between NUM_VOICES phase-accumulator voices.
// Each frame issues one read per voice, then sums the returned samples into one output sample.
module wavetable_voice_sched #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int ROM_LAT    = 2,
  parameter int SAMPLE_DIV = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_VOICES-1:0]         voice_en,
  input  logic [NUM_VOICES*PHASE_W-1:0] voice_inc,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic [15:0]                   sample,
  output logic                          sample_valid,
  output logic                          busy
);

  localparam int ACC_W = DATA_W + $clog2(NUM_VOICES);
  localparam int TIM_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_VOICES + 1);
  localparam int CNT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state;
  logic [TIM_W-1:0]     timer;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     drain_cnt;
  logic [ACC_W-1:0]     acc;
  logic [ROM_LAT:0]     tag;
  logic [PHASE_W-1:0]   phase [NUM_VOICES];

  logic                 issue_go;
  logic [IDX_W-1:0]     issue_slot;
  logic                 slot_en;
  logic [PHASE_W-1:0]   slot_inc;
  logic [ADDR_W-1:0]    slot_addr;
  logic [PHASE_W-1:0]   slot_phase_nxt;

  // Select the voice whose ROM read is registered at the coming edge.
  always_comb begin
    issue_go       = 1'b0;
    issue_slot     = '0;
    slot_en        = 1'b0;
    slot_inc       = '0;
    slot_addr      = '0;
    if (state == IDLE && timer == '0) begin
      issue_go   = 1'b1;
      issue_slot = '0;
    end else if (state == ISSUE && idx != IDX_W'(NUM_VOICES - 1)) begin
      issue_go   = 1'b1;
      issue_slot = idx + IDX_W'(1);
    end else begin
      issue_go   = 1'b0;
      issue_slot = '0;
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (issue_slot == IDX_W'(v)) begin
        slot_en   = voice_en[v];
        slot_inc  = voice_inc[v*PHASE_W +: PHASE_W];
        slot_addr = phase[v][PHASE_W-1 -: ADDR_W];
      end else begin
        slot_en   = slot_en;
      end
    end
    // A disabled voice restarts from phase 0 so re-enabling begins at rom[0].
    slot_phase_nxt = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (issue_slot == IDX_W'(v) && slot_en) begin
        slot_phase_nxt = phase[v] + slot_inc;
      end else begin
        slot_phase_nxt = slot_phase_nxt;
      end
    end
  end

  // Frame timer, scheduling FSM, phase accumulators, enable tag pipeline and mixer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      idx          <= '0;
      drain_cnt    <= '0;
      acc          <= '0;
      tag          <= '0;
      rom_addr     <= '0;
      sample       <= 16'd0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) phase[v] <= '0;
    end else begin
      timer        <= (timer == TIM_W'(SAMPLE_DIV - 1)) ? '0 : timer + TIM_W'(1);
      sample_valid <= 1'b0;
      tag          <= {tag[ROM_LAT-1:0], issue_go & slot_en};
      rom_addr     <= (issue_go && slot_en) ? slot_addr : '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (issue_go && issue_slot == IDX_W'(v)) phase[v] <= slot_phase_nxt;
      end
      // The tag leaving the pipeline lines up with the rom_data of its own read.
      if (state == IDLE && timer == '0) begin
        acc <= '0;
      end else if (tag[ROM_LAT]) begin
        acc <= acc + ACC_W'(rom_data);
      end else begin
        acc <= acc;
      end
      case (state)
        IDLE: begin
          if (timer == '0) begin
            state <= ISSUE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (idx == IDX_W'(NUM_VOICES - 1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == CNT_W'(ROM_LAT - 1)) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          sample       <= 16'(acc);
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wavetable_voice_sched.sv
// Self-checking bench for wavetable_voice_sched: a frame-level reference model computes the
// expected per-slot addresses, busy window, strobe cycle and mixed sum from a ROM image.
module tb_wavetable_voice_sched;

  localparam int NV   = 4;
  localparam int DIV  = 256;
  localparam int LAT  = NV + 2 + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  voice_en = 4'd0;
  logic [63:0] voice_inc = 64'd0;
  logic [6:0]  rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic [15:0] sample;
  logic        sample_valid;
  logic        busy;

  logic [7:0]  rom_mem [128];
  logic [7:0]  rd1 = 8'd0;
  logic [15:0] mphase [NV];
  logic [15:0] hold_sample;
  logic [6:0]  got_addr [NV];
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic [3:0]  en;
    logic [63:0] inc;
    int          rom_mode;
    bit          chk_const;
    logic [15:0] exp_sample;
  } vec_t;
  vec_t tbl [6];

  wavetable_voice_sched dut (
    .clk(clk), .rst(rst), .voice_en(voice_en), .voice_inc(voice_inc),
    .rom_addr(rom_addr), .rom_data(rom_data), .sample(sample),
    .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Two-cycle registered ROM.
  always @(posedge clk) begin
    rd1      <= rom_mem[rom_addr];
    rom_data <= rd1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_rom(input int mode);
    for (int a = 0; a < 128; a++) begin
      if (mode == 0) rom_mem[a] = 8'(a);
      else if (mode == 1) rom_mem[a] = 8'hFF;
      else rom_mem[a] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sample", sample, 16'd0);
    chk("reset_valid", sample_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_addr", rom_addr, 7'd0);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) mphase[i] = 16'd0;
    hold_sample = 16'd0;
  endtask

  // Runs one whole frame; the next posedge must be the frame-start edge.
  task automatic run_frame(input bit chk_const, input logic [15:0] cexp);
    logic [6:0]  ea [NV];
    logic [15:0] esum;
    logic [15:0] inc;
    esum = 16'd0;
    for (int i = 0; i < NV; i++) begin
      inc = voice_inc[i*16 +: 16];
      ea[i] = voice_en[i] ? mphase[i][15:9] : 7'd0;
      if (voice_en[i]) begin
        esum = esum + 16'(rom_mem[ea[i]]);
        mphase[i] = mphase[i] + inc;
      end else begin
        mphase[i] = 16'd0;
      end
    end
    for (int k = 0; k < DIV; k++) begin
      @(posedge clk);
      #1;
      if (k < NV) begin
        chk("rom_addr_slot", rom_addr, ea[k]);
        got_addr[k] = rom_addr;
      end else begin
        chk("rom_addr_idle", rom_addr, 7'd0);
      end
      chk("busy", busy, (k < LAT) ? 1'b1 : 1'b0);
      chk("sample_valid", sample_valid, (k == LAT) ? 1'b1 : 1'b0);
      chk("sample", sample, (k < LAT) ? hold_sample : esum);
      if (k == LAT && chk_const) chk("sample_const", sample, cexp);
    end
    hold_sample = esum;
  endtask

  initial begin
    tbl[0] = '{4'h0, 64'h1111_2222_3333_4444, 0, 1'b1, 16'h0000};
    tbl[1] = '{4'hF, 64'h0123_4567_89AB_CDEF, 1, 1'b1, 16'h03FC};
    tbl[2] = '{4'h1, 64'h0400_0300_0200_0100, 1, 1'b1, 16'h00FF};
    tbl[3] = '{4'h5, 64'hFFFF_0001_7FFF_8000, 1, 1'b1, 16'h01FE};
    tbl[4] = '{4'hF, 64'h0800_0600_0400_0200, 0, 1'b0, 16'h0000};
    tbl[5] = '{4'hA, 64'h1000_0A00_0300_0900, 0, 1'b0, 16'h0000};

    // Idle voices: strobe 7 cycles after release, then every 256 cycles, silence.
    set_rom(0);
    do_reset();
    run_frame(1'b1, 16'h0000);
    run_frame(1'b1, 16'h0000);

    // Table-driven vectors, two frames each.
    for (int r = 0; r < 6; r++) begin
      set_rom(tbl[r].rom_mode);
      voice_en  = tbl[r].en;
      voice_inc = tbl[r].inc;
      run_frame(tbl[r].chk_const, tbl[r].exp_sample);
      run_frame(tbl[r].chk_const, tbl[r].exp_sample);
    end

    // Identity ROM, voice 0 stepping one address per frame, wraps after 128 frames.
    set_rom(0);
    voice_en = 4'd0;
    do_reset();
    voice_en  = 4'b0001;
    voice_inc = 64'h0000_0000_0000_0200;
    for (int f = 0; f < 130; f++) run_frame(1'b1, 16'(f % 128));

    // Voice 2 with the largest increment wraps its phase downward.
    do_reset();
    voice_en  = 4'b0100;
    voice_inc = 64'h0000_FFFF_0000_0000;
    run_frame(1'b0, 16'h0);
    chk("v2_slot_addr_f0", got_addr[2], 7'h00);
    run_frame(1'b0, 16'h0);
    chk("v2_slot_addr_f1", got_addr[2], 7'h7F);

    // Voice 1 gated off for a frame restarts from rom[0].
    do_reset();
    voice_en  = 4'b0010;
    voice_inc = 64'h0000_0000_1234_0000;
    run_frame(1'b0, 16'h0);
    run_frame(1'b0, 16'h0);
    chk("v1_running_addr", got_addr[1], 7'h09);
    voice_en = 4'b0000;
    run_frame(1'b1, 16'h0000);
    chk("v1_gated_addr", got_addr[1], 7'h00);
    voice_en = 4'b0010;
    run_frame(1'b0, 16'h0);
    chk("v1_reenable_addr", got_addr[1], 7'h00);

    // Reset during cycle T+3 aborts the frame.
    set_rom(1);
    do_reset();
    voice_en = 4'hF;
    run_frame(1'b1, 16'h03FC);
    for (int k = 0; k < 4; k++) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("abort_valid", sample_valid, 1'b0);
      chk("abort_sample", sample, 16'd0);
      chk("abort_busy", busy, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < NV; i++) mphase[i] = 16'd0;
    hold_sample = 16'd0;
    run_frame(1'b1, 16'h03FC);

    // Randomized voices and ROM image against the frame model.
    set_rom(2);
    for (int r = 0; r < 8; r++) begin
      voice_en  = 4'($urandom);
      voice_inc = {$urandom, $urandom};
      run_frame(1'b0, 16'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
